// File: rtl/neuron_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | neuron_pkg : shared widths, function codes and saturation helper      |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
package neuron_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_BETA_W = 8;

    localparam logic FUNC_LEAK      = 1'b0;
    localparam logic FUNC_INTEGRATE = 1'b1;

    typedef enum logic [1:0] {
        SAT_PASS = 2'd0,
        SAT_ZERO = 2'd1,
        SAT_MAX  = 2'd2
    } sat_e;

    // Classifies a two-guard-bit signed sum by its top two bits.
    function automatic sat_e sat_kind(input logic [1:0] i_top);
        if (i_top[1]) begin
            return SAT_ZERO;
        end else if (i_top[0]) begin
            return SAT_MAX;
        end
        return SAT_PASS;
    endfunction

endpackage
`default_nettype wire

// File: rtl/neuron_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | neuron_if : request/response bundle between scheduler and neuron      |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
interface neuron_if
    import neuron_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int BETA_W = DEF_BETA_W
);
    logic              valid_i;
    logic [DATA_W-1:0] weight;
    logic [DATA_W-1:0] v_mem_in;
    logic [BETA_W-1:0] beta;
    logic              function_sel;
    logic [DATA_W-1:0] v_th;
    logic              valid_o;
    logic              spike;
    logic [DATA_W-1:0] v_mem_out;

    modport master (
        output valid_i, weight, v_mem_in, beta, function_sel, v_th,
        input  valid_o, spike, v_mem_out
    );

    modport slave (
        input  valid_i, weight, v_mem_in, beta, function_sel, v_th,
        output valid_o, spike, v_mem_out
    );
endinterface
`default_nettype wire

// File: rtl/neuron_sat_add.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | neuron_sat_add : unsigned + signed add clamped to [0, 2^DATA_W-1]     |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
module neuron_sat_add
    import neuron_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  wire logic [DATA_W-1:0] i_v,
    input  wire logic [DATA_W-1:0] i_w,
    output logic      [DATA_W-1:0] o_sum
);

    logic signed [DATA_W+1:0] w_sum;

    assign w_sum = $signed({2'b00, i_v}) + $signed({{2{i_w[DATA_W-1]}}, i_w});

    always_comb begin
        o_sum = w_sum[DATA_W-1:0];
        case (sat_kind(w_sum[DATA_W+1:DATA_W]))
            SAT_ZERO: o_sum = '0;
            SAT_MAX:  o_sum = '1;
            default:  o_sum = w_sum[DATA_W-1:0];
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/neuron.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | neuron : single LIF neuron datapath, 1-cycle latency, fully pipelined |
// |          Define NEURON_SOFT_RESET_EN for subtractive reset on spike.  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module neuron
    import neuron_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int BETA_W = DEF_BETA_W
) (
    input wire logic clock,
    input wire logic reset_n,
    neuron_if.slave  bus
);

    logic [DATA_W+BETA_W-1:0] w_prod;
    logic [DATA_W-1:0]        w_leak;
    logic [DATA_W-1:0]        w_sum;
    logic [DATA_W-1:0]        w_fire_v;
    logic                     w_fire;
    logic [DATA_W-1:0]        w_next_v;
    logic                     w_next_spike;

    logic                     r_valid;
    logic                     r_spike;
    logic [DATA_W-1:0]        r_v_mem;

    assign w_prod = {{BETA_W{1'b0}}, bus.v_mem_in} * {{DATA_W{1'b0}}, bus.beta};
    assign w_leak = DATA_W'(w_prod >> BETA_W);

    neuron_sat_add #(
        .DATA_W (DATA_W)
    ) u_sat_add (
        .i_v   (bus.v_mem_in),
        .i_w   (bus.weight),
        .o_sum (w_sum)
    );

    // A zero threshold disables firing so the neuron acts as a pure accumulator.
    assign w_fire = (bus.function_sel == FUNC_INTEGRATE) && (bus.v_th != '0)
                    && (w_sum >= bus.v_th);

`ifdef NEURON_SOFT_RESET_EN
    assign w_fire_v = w_sum - bus.v_th;
`else
    assign w_fire_v = '0;
`endif

    always_comb begin
        w_next_spike = 1'b0;
        w_next_v     = w_leak;
        if (bus.function_sel == FUNC_INTEGRATE) begin
            w_next_spike = w_fire;
            w_next_v     = w_fire ? w_fire_v : w_sum;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_spike <= 1'b0;
            r_v_mem <= '0;
        end else begin
            r_valid <= bus.valid_i;
            if (bus.valid_i) begin
                r_spike <= w_next_spike;
                r_v_mem <= w_next_v;
            end
        end
    end

    assign bus.valid_o   = r_valid;
    assign bus.spike     = r_spike;
    assign bus.v_mem_out = r_v_mem;

endmodule
`default_nettype wire

// File: tb/tb_neuron.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_neuron : directed + randomized self-checking bench for neuron      |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_neuron;

    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    neuron_if #(.DATA_W(8), .BETA_W(8)) u_if ();

    neuron #(.DATA_W(8), .BETA_W(8)) u_dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef NEURON_SOFT_RESET_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif

    // Reference LIF rule in plain integer arithmetic.
    task automatic lif_model(input int v, input logic [7:0] w8, input int b, input logic sel,
                             input int vth, output logic sp, output int vo);
        int w;
        int s;
        w = (w8 >= 8'd128) ? int'(w8) - 256 : int'(w8);
        sp = 1'b0;
        if (!sel) begin
            vo = (v * b) / 256;
        end else begin
            s = v + w;
            if (s < 0)   s = 0;
            if (s > 255) s = 255;
            if (vth != 0 && s >= vth) begin
                sp = 1'b1;
                vo = SOFT ? s - vth : 0;
            end else begin
                vo = s;
            end
        end
    endtask

    logic exp_valid = 1'b0;
    logic exp_spike = 1'b0;
    int   exp_v     = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                exp_valid = 1'b0;
                exp_spike = 1'b0;
                exp_v     = 0;
            end else begin
                exp_valid = u_if.valid_i;
                if (u_if.valid_i)
                    lif_model(int'(u_if.v_mem_in), u_if.weight, int'(u_if.beta),
                              u_if.function_sel, int'(u_if.v_th), exp_spike, exp_v);
            end
        end
    end

    // Per-cycle compare of DUT outputs against the model.
    initial begin
        @(posedge clk);
        forever begin
            #2;
            tests++;
            if (u_if.valid_o !== exp_valid) begin
                fails++;
                $display("FAIL model_valid t=%0t got=%b exp=%b", $time, u_if.valid_o, exp_valid);
            end
            tests++;
            if (u_if.spike !== exp_spike) begin
                fails++;
                $display("FAIL model_spike t=%0t got=%b exp=%b", $time, u_if.spike, exp_spike);
            end
            tests++;
            if (u_if.v_mem_out !== 8'(exp_v)) begin
                fails++;
                $display("FAIL model_vmem t=%0t got=%0d exp=%0d", $time, u_if.v_mem_out, exp_v);
            end
            @(posedge clk);
        end
    end

    task automatic step(input int v, input int w, input int b, input logic sel, input int vth);
        @(negedge clk);
        u_if.valid_i      = 1'b1;
        u_if.v_mem_in     = 8'(v);
        u_if.weight       = 8'(w);
        u_if.beta         = 8'(b);
        u_if.function_sel = sel;
        u_if.v_th         = 8'(vth);
        @(posedge clk);
        #3;
    endtask

    task automatic idle();
        @(negedge clk);
        u_if.valid_i      = 1'b0;
        u_if.v_mem_in     = 8'($urandom_range(0, 255));
        u_if.weight       = 8'($urandom_range(0, 255));
        u_if.beta         = 8'($urandom_range(0, 255));
        u_if.function_sel = 1'($urandom_range(0, 1));
        u_if.v_th         = 8'($urandom_range(0, 255));
        @(posedge clk);
        #3;
    endtask

    task automatic chk(input string name, input logic ev, input logic es, input int evm);
        tests++;
        if (u_if.valid_o !== ev || u_if.spike !== es || u_if.v_mem_out !== 8'(evm)) begin
            fails++;
            $display("FAIL %s got valid=%b spike=%b v=%0d exp valid=%b spike=%b v=%0d",
                     name, u_if.valid_o, u_if.spike, u_if.v_mem_out, ev, es, evm);
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        u_if.valid_i      = 1'b1;
        u_if.v_mem_in     = 8'd200;
        u_if.weight       = 8'd50;
        u_if.beta         = 8'd200;
        u_if.function_sel = 1'b1;
        u_if.v_th         = 8'd10;
        repeat (2) @(posedge clk);
        #3;
        chk("reset", 1'b0, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        step(200, 0, 128, 1'b0, 0);    chk("leak_half", 1'b1, 1'b0, 100);
        step(1, 0, 255, 1'b0, 0);      chk("leak_v1_b255", 1'b1, 1'b0, 0);
        step(255, 0, 255, 1'b0, 0);    chk("leak_v255_b255", 1'b1, 1'b0, 254);
        step(100, 0, 0, 1'b0, 1);      chk("leak_b0", 1'b1, 1'b0, 0);
        step(10, 20, 0, 1'b1, 50);     chk("int_nofire", 1'b1, 1'b0, 30);
        step(10, -20, 0, 1'b1, 50);    chk("int_clamp0", 1'b1, 1'b0, 0);
        step(200, -128, 0, 1'b1, 0);   chk("int_wmin", 1'b1, 1'b0, 72);
        step(40, 20, 0, 1'b1, 50);     chk("fire", 1'b1, 1'b1, SOFT ? 10 : 0);
        step(250, 127, 0, 1'b1, 0);    chk("sat_vth0", 1'b1, 1'b0, 255);
        step(250, 127, 0, 1'b1, 255);  chk("sat_fire255", 1'b1, 1'b1, 0);
        idle();                        chk("hold_idle", 1'b0, 1'b1, 0);
        step(30, 20, 0, 1'b1, 50);     chk("fire_equal", 1'b1, 1'b1, 0);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) < 8) begin
                step(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 255)));
            end else begin
                idle();
            end
            if (i == 1000) begin
                @(negedge clk);
                rst_n = 1'b0;
                @(posedge clk);
                #3;
                chk("mid_reset", 1'b0, 1'b0, 0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
